// File: rtl/fred_checkout_sequencer.sv
// Checkout item list: buffers scanned {U,P,C} codes in order and replays them
// to the item-name display decoder with a fixed hold time and a blanking gap.
module fred_checkout_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scan_valid,
    input  logic [2:0]                 scan_code,
    input  logic                       play,
    input  logic                       clear,
    output logic                       U,
    output logic                       P,
    output logic                       C,
    output logic                       disp_en,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       reject
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      upc_q, upc_d;
    logic            disp_en_q, disp_en_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            reject_q, reject_d;
    logic [2:0]      mem_q [DEPTH];

    logic            mem_we;
    logic            accept;
    logic            code_ok;
    logic            last;
    logic [IW-1:0]   nxt_idx;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        upc_d     = upc_q;
        disp_en_d = disp_en_q;
        busy_d    = busy_q;
        full_d    = full_q;
        reject_d  = 1'b0;
        mem_we    = 1'b0;
        accept    = 1'b0;
        code_ok   = (scan_code != 3'b010) && (scan_code != 3'b111);
        last      = (CW'(idx_q) == count_q - CW'(1));
        nxt_idx   = idx_q + IW'(1);

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    count_d = '0;
                    full_d  = 1'b0;
                end else begin
                    accept = scan_valid && code_ok && (count_q < CW'(DEPTH));
                    if (scan_valid && !accept) reject_d = 1'b1;
                    if (accept) begin
                        mem_we  = 1'b1;
                        count_d = count_q + CW'(1);
                        full_d  = (count_d == CW'(DEPTH));
                    end
                    // A scan accepted on the play edge into an empty list is item 0.
                    if (play && (count_d != '0)) begin
                        state_d   = S_SHOW;
                        idx_d     = '0;
                        timer_d   = '0;
                        upc_d     = (count_q == '0) ? scan_code : mem_q[0];
                        disp_en_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            S_SHOW: begin
                reject_d = scan_valid;
                if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                    timer_d = '0;
                    if (last) begin
                        state_d   = S_IDLE;
                        disp_en_d = 1'b0;
                        busy_d    = 1'b0;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        disp_en_d = 1'b0;
                    end else begin
                        idx_d = nxt_idx;
                        upc_d = mem_q[nxt_idx];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                reject_d = scan_valid;
                if (timer_q == TW'(GLAST)) begin
                    state_d   = S_SHOW;
                    timer_d   = '0;
                    idx_d     = nxt_idx;
                    upc_d     = mem_q[nxt_idx];
                    disp_en_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            upc_q     <= 3'b000;
            disp_en_q <= 1'b0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            upc_q     <= upc_d;
            disp_en_q <= disp_en_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            reject_q  <= reject_d;
            if (mem_we) mem_q[IW'(count_q)] <= scan_code;
        end
    end

    assign {U, P, C} = upc_q;
    assign disp_en   = disp_en_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign full      = full_q;
    assign reject    = reject_q;
endmodule

// File: doc/fred_checkout_sequencer.md
Name: fred_checkout_sequencer

Overview:
- Checkout controller for the store's item display.
- Accepts a stream of scanned 3-bit UPC codes {U,P,C} into a small in-order list.
- On request, replays the stored items one at a time onto the UPC inputs of the item-name 7-segment decoder, holding each for a fixed time with a blanking gap between items.
- Sits between the switch/scan front end and the display decoder; the top level blanks all six HEX displays whenever disp_en is low.

Parameters:
DEPTH, 8, maximum number of stored items (power of 2 not required, >=1)
HOLD_CYCLES, 4, clock cycles each item is shown (>=1; board build overrides to 50_000_000)
GAP_CYCLES, 1, blank cycles between consecutive items (0 = no gap)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
scan_valid  input  1  one-cycle strobe: scan_code is a new scanned item
scan_code  input  3  scanned item code {U,P,C}
play  input  1  one-cycle strobe: start replaying stored items
clear  input  1  one-cycle strobe: empty the item list
U  output  1  item code MSB to display decoder
P  output  1  item code middle bit to display decoder
C  output  1  item code LSB to display decoder
disp_en  output  1  1 = show decoded item, 0 = displays blank
busy  output  1  1 while a replay is in progress
count  output  $clog2(DEPTH+1)  number of stored items
full  output  1  count == DEPTH
reject  output  1  one-cycle pulse: scan_valid was not accepted

Behaviour:
- Reset (sampled high on an edge): state IDLE, count=0, {U,P,C}=3'b000, disp_en=0, busy=0, full=0, reject=0, index=0, hold timer=0. Stored list contents are don't-care. Reset mid-replay aborts immediately.
- All outputs are registered.
- Valid codes: 000 bed, 001 pot, 011 cap, 100 ball, 101 rug, 110 pipe. Codes 010 and 111 are invalid.
- Scan acceptance:
  - A scan is accepted only when state==IDLE, count<DEPTH, and the code is valid.
  - Accepted: written at position count; count increments on the same edge.
  - Any other scan_valid: no storage change; reject=1 for exactly the next cycle.
  - reject is 0 whenever scan_valid was low.
- States:
  - IDLE: disp_en=0, busy=0, {U,P,C} hold their last value.
    - play with count>0 -> SHOW: index=0, {U,P,C}=item[0], disp_en=1, busy=1, all on the same edge that samples play.
    - play with count==0 is ignored.
  - SHOW: the item is displayed for exactly HOLD_CYCLES cycles. On expiry:
    - If index==count-1 -> IDLE: disp_en=0, busy=0.
    - Else if GAP_CYCLES>0 -> GAP: disp_en=0.
    - Else -> SHOW with index+1: {U,P,C}=next item, disp_en stays 1.
  - GAP: disp_en=0, busy=1, lasts exactly GAP_CYCLES cycles, then -> SHOW with index+1 and the new item.
- Replay does not consume items; the list persists and may be replayed again.
- clear in IDLE: count=0 and full=0 on the next edge. clear while busy is ignored.
- Simultaneous events in IDLE:
  - clear and play: clear wins, play ignored.
  - clear and scan_valid: clear wins; the scan is dropped without a reject.
  - play and accepted scan: the scan is stored and the replay includes it (the count used for the end check is the incremented value).
- play while busy is ignored (no restart).
- Total replay length for N items: N*HOLD_CYCLES + (N-1)*GAP_CYCLES cycles with busy=1.

Test Plan:
- Reset, then scan 001, 011, 100 -> count=3, reject never set. Play -> {U,P,C} shows 001 for 4 cycles, disp_en low 1 cycle, 011 for 4, gap, 100 for 4, then busy=0, disp_en=0; busy high for 14 cycles total.
- Scan 010 and 111 in IDLE -> reject pulses 1 cycle each, count unchanged at 0. Play with count=0 -> busy stays 0.
- Fill 8 valid codes -> full=1, count=8. 9th scan 000 -> reject=1, count stays 8. Clear -> count=0, full=0.
- During replay of 2 items: scan 101 -> reject=1, count unchanged. Clear and play -> ignored, replay completes normally.
- Same cycle in IDLE with count=1: play + scan 110 -> count=2, replay shows item0 then 110. Same cycle clear + play -> count=0, busy stays 0.
- Assert reset during SHOW of item 1 of 3 -> next cycle: disp_en=0, busy=0, count=0, {U,P,C}=000.
